eisv_dmem_responder: RTL and testbench
======================================

// Module: eisv_dmem_responder
// PURPOSE
//  Responder (memory side) of the EIS-V data-memory interface driven by the core's dmem_* ports.
//  Decodes each request into a word-addressed RAM, a small MMIO timer block, or an unmapped region.
//  Returns read data one cycle after the request and applies byte-enabled writes.
//  Drives the core's timer_interrupt_pending input from an mtime/mtimecmp comparator.
//  Instantiated next to the core in simulation wrappers and FPGA tops.
// PARAMETERS
//  MEM_WORDS   4096           RAM depth in 32-bit words; must be a power of 2. RAM spans 0 .. MEM_WORDS*4-1.
//  MMIO_BASE   32'h8000_0000  Base of the 256-byte timer MMIO window; must be 256-byte aligned.
// PORTS
//  clk_i                    in   1   clock; all state updates on the rising edge
//  rst_i                    in   1   asynchronous, active-high reset
//  dmem_addr_i              in   32  byte address; addr[1:0] is ignored (word access)
//  dmem_ren_i               in   1   read request, sampled at the clock edge
//  dmem_rdata_o             out  32  read data, valid 1 cycle after the ren edge
//  dmem_wen_i               in   1   write request, sampled at the clock edge
//  dmem_wdata_i             in   32  write data
//  dmem_byte_enable_i       in   4   write lane enables; bit i selects wdata[8i+7:8i]
//  timer_interrupt_pending_o out 1   registered flag: mtime >= mtimecmp (unsigned, 64-bit)
//  access_fault_o           out  1   1-cycle pulse on any ren/wen that hits an unmapped address
// BEHAVIOUR
//  Reset (async, active-high):
//   - dmem_rdata_o=0, timer_interrupt_pending_o=0, access_fault_o=0.
//   - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale=0, prescale counter=0.
//   - RAM contents are NOT reset and survive a reset asserted mid-operation.
//  Address decode (priority order):
//   1. MMIO when addr[31:8]==MMIO_BASE[31:8].
//   2. RAM when addr < MEM_WORDS*4.
//   3. Otherwise unmapped.
//  Read:
//   - ren=1 at edge N -> dmem_rdata_o holds the word at edge N+1; latency is exactly 1 cycle.
//   - With ren=0, dmem_rdata_o holds its last value.
//   - Unmapped read: rdata=0 and access_fault_o=1 for one cycle.
//  Write:
//   - wen=1 updates only the lanes with byte_enable=1; be=4'b0000 is a legal no-op.
//   - Unmapped write: no state change; access_fault_o pulses.
//  ren and wen in the same cycle to the same word: the write is performed and the read returns
//   the OLD word (read-before-write). For MMIO, read returns the pre-update register value.
//  MMIO map (offset from MMIO_BASE; byte enables apply):
//   0x00 mtime[31:0]   0x04 mtime[63:32]   0x08 mtimecmp[31:0]   0x0C mtimecmp[63:32]
//   0x10 prescale[15:0] (upper bits read 0)
//   Other offsets read 0, ignore writes, and do not fault.
//  Timer:
//   - 16-bit prescale counter counts 0..prescale.
//   - On the cycle the counter equals prescale: counter->0 and mtime += 1.
//   - prescale=0 -> mtime increments every cycle.
//   - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
//   - A software write to either mtime half overrides that cycle's increment on the written bytes;
//     the non-written half keeps its incremented value. No carry is propagated between halves
//     on a write cycle.
//  timer_interrupt_pending_o:
//   - Registered from (next mtime >= next mtimecmp).
//   - Updates the cycle after any mtime/mtimecmp change.
//   - Clears one cycle after software raises mtimecmp above mtime.
// TESTING
//  1. RAM R/W: wen, addr 0x10, wdata 0xDEADBEEF, be 4'hF; next cycle ren, addr 0x10
//     -> rdata = 0xDEADBEEF exactly 1 cycle after the ren edge.
//  2. Byte lanes: word 0x10 = 0xDEADBEEF; write 0x000000AA with be 4'b0001
//     -> read 0xDEADBEAA; then be 4'b0000 -> value unchanged.
//  3. RAW same cycle: word = 0x11111111; ren+wen same cycle, wdata 0x22222222
//     -> rdata = 0x11111111; next read -> 0x22222222.
//  4. Unmapped: ren at 0x4000_0000 with MEM_WORDS=4096
//     -> rdata = 0 and access_fault_o high for exactly 1 cycle; RAM unchanged.
//  5. Timer: prescale=0, mtimecmp = {0, 32'd20}, mtime written 0
//     -> pending rises the cycle after mtime reaches 20; write mtimecmp lo = 1000 -> pending low next cycle.
//  6. Wrap/reset: mtime = 64'hFFFF_FFFF_FFFF_FFFE, prescale=0 -> reads 0 two increments later;
//     assert rst_i mid-run -> pending=0, mtime=0, and RAM word 0x10 still reads its pre-reset value.

Source files
------------

// File: rtl/eisv_dmem_responder.sv
// eisv_dmem_responder
//   Memory-side responder for the EIS-V core's data-memory port.
//   Each request is decoded to one of three targets:
//     - MMIO timer window (256 bytes at MMIO_BASE), checked first
//     - word-addressed RAM of MEM_WORDS words starting at address 0
//     - unmapped (reads return 0; access_fault_o pulses for one cycle)
//   Read data is registered and appears one cycle after the ren edge. It holds
//   its value while ren is low. Writes are byte-lane enabled. A read and a
//   write to the same word in the same cycle return the old contents.
//   The timer block provides mtime, mtimecmp and a 16-bit prescaler.
//   timer_interrupt_pending_o is the registered result of mtime >= mtimecmp.
//
// Ports
//   clk_i                     in   1   clock, rising edge
//   rst_i                     in   1   asynchronous active-high reset (RAM not reset)
//   dmem_addr_i               in   32  byte address, bits [1:0] ignored
//   dmem_ren_i                in   1   read request
//   dmem_rdata_o              out  32  read data, one cycle after request
//   dmem_wen_i                in   1   write request
//   dmem_wdata_i              in   32  write data
//   dmem_byte_enable_i        in   4   write lane enables
//   timer_interrupt_pending_o out  1   mtime >= mtimecmp (registered)
//   access_fault_o            out  1   pulse on a request to an unmapped address
//
// Handshake: there is no backpressure. A request is accepted on every rising
// edge where ren or wen is high, and the response is never stalled.

module eisv_dmem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_ren_i,
    output logic [31:0] dmem_rdata_o,
    input  logic        dmem_wen_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_byte_enable_i,
    output logic        timer_interrupt_pending_o,
    output logic        access_fault_o
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    logic [31:0] r_mem [0:MEM_WORDS-1];

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [15:0] r_prescale;
    logic [15:0] r_presc_cnt;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        r_pending;

    logic          w_is_mmio;
    logic          w_is_ram;
    logic          w_unmapped;
    logic [AW-1:0] w_word_idx;
    logic [5:0]    w_mmio_off;
    logic          w_mmio_wr;
    logic [31:0]   w_mmio_rdata;
    logic          w_tick;
    logic [15:0]   w_cnt_next;
    logic [63:0]   w_mtime_inc;
    logic [63:0]   w_mtime_next;
    logic [63:0]   w_mtimecmp_next;
    logic [15:0]   w_prescale_next;
    logic          w_unused;

    // Sub-word address bits are not part of any decode.
    assign w_unused = ^dmem_addr_i[1:0];

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Decode. MMIO wins over RAM when the two windows overlap.
    assign w_is_mmio  = (dmem_addr_i[31:8] == MMIO_BASE[31:8]);
    assign w_is_ram   = !w_is_mmio && ({1'b0, dmem_addr_i} < RAM_BYTES);
    assign w_unmapped = !w_is_mmio && !w_is_ram;
    assign w_word_idx = dmem_addr_i[AW+1:2];
    assign w_mmio_off = dmem_addr_i[7:2];
    assign w_mmio_wr  = dmem_wen_i && w_is_mmio;

    // MMIO read mux. It shows the register values from before this edge's update.
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_mmio_off)
            6'd0:    w_mmio_rdata = r_mtime[31:0];
            6'd1:    w_mmio_rdata = r_mtime[63:32];
            6'd2:    w_mmio_rdata = r_mtimecmp[31:0];
            6'd3:    w_mmio_rdata = r_mtimecmp[63:32];
            6'd4:    w_mmio_rdata = {16'h0, r_prescale};
            default: w_mmio_rdata = 32'h0;
        endcase
    end

    // Timer next-state logic. A software write is merged over the already
    // incremented mtime, so the half that is not written keeps its increment.
    // The >= comparison stops a counter that is already past a newly lowered
    // prescale from running all the way around.
    always_comb begin
        w_tick          = (r_presc_cnt >= r_prescale);
        w_cnt_next      = w_tick ? 16'h0 : (r_presc_cnt + 16'd1);
        w_mtime_inc     = r_mtime + 64'(w_tick);
        w_mtime_next    = w_mtime_inc;
        w_mtimecmp_next = r_mtimecmp;
        w_prescale_next = r_prescale;
        if (w_mmio_wr) begin
            case (w_mmio_off)
                6'd0: w_mtime_next[31:0]     = f_merge(w_mtime_inc[31:0], dmem_wdata_i, dmem_byte_enable_i);
                6'd1: w_mtime_next[63:32]    = f_merge(w_mtime_inc[63:32], dmem_wdata_i, dmem_byte_enable_i);
                6'd2: w_mtimecmp_next[31:0]  = f_merge(r_mtimecmp[31:0], dmem_wdata_i, dmem_byte_enable_i);
                6'd3: w_mtimecmp_next[63:32] = f_merge(r_mtimecmp[63:32], dmem_wdata_i, dmem_byte_enable_i);
                6'd4: begin
                    if (dmem_byte_enable_i[0]) w_prescale_next[7:0]  = dmem_wdata_i[7:0];
                    if (dmem_byte_enable_i[1]) w_prescale_next[15:8] = dmem_wdata_i[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata     <= 32'h0;
            r_fault     <= 1'b0;
            r_pending   <= 1'b0;
            r_mtime     <= 64'h0;
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_prescale  <= 16'h0;
            r_presc_cnt <= 16'h0;
        end else begin
            if (dmem_ren_i) begin
                if (w_is_mmio)     r_rdata <= w_mmio_rdata;
                else if (w_is_ram) r_rdata <= r_mem[w_word_idx];
                else               r_rdata <= 32'h0;
            end
            r_fault     <= (dmem_ren_i || dmem_wen_i) && w_unmapped;
            r_mtime     <= w_mtime_next;
            r_mtimecmp  <= w_mtimecmp_next;
            r_prescale  <= w_prescale_next;
            r_presc_cnt <= w_cnt_next;
            r_pending   <= (w_mtime_next >= w_mtimecmp_next);
        end
    end

    // The RAM has no reset, so its contents survive rst_i. Writes are
    // blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (dmem_wen_i && w_is_ram && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_byte_enable_i[i]) r_mem[w_word_idx][8*i +: 8] <= dmem_wdata_i[8*i +: 8];
            end
        end
    end

    assign dmem_rdata_o              = r_rdata;
    assign access_fault_o            = r_fault;
    assign timer_interrupt_pending_o = r_pending;

endmodule

// File: tb/tb_eisv_dmem_responder.sv
// Testbench for eisv_dmem_responder.
// The reference model updates on every rising edge. It keeps RAM as a sparse
// word map and holds the timer as plain 64-bit values. For each edge it pushes
// the expected {pending, fault, rdata}. A monitor on the falling edge pops one
// entry and compares it with the DUT outputs.

module tb_eisv_dmem_responder;

    localparam int unsigned MEM_WORDS = 4096;
    localparam logic [31:0] MMIO      = 32'h8000_0000;
    localparam int          W         = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] rdata;
    logic        pending;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    eisv_dmem_responder #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .dmem_addr_i              (addr),
        .dmem_ren_i               (ren),
        .dmem_rdata_o             (rdata),
        .dmem_wen_i               (wen),
        .dmem_wdata_i             (wdata),
        .dmem_byte_enable_i       (be),
        .timer_interrupt_pending_o(pending),
        .access_fault_o           (fault)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_mem[int];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [15:0] m_presc;
    int          m_cnt;
    logic [31:0] m_rdata;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mtime = 64'h0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_presc = 16'h0;
            m_cnt   = 0;
            m_rdata = 32'h0;
            exp_q.delete();
        end else begin
            logic        is_mmio, is_ram, flt;
            logic [31:0] off;
            logic [63:0] t_n, c_n;
            logic [15:0] p_n;
            int          idx;
            is_mmio = (addr & 32'hFFFF_FF00) == MMIO;
            is_ram  = !is_mmio && (addr < MEM_WORDS * 4);
            off     = addr & 32'h0000_00FC;
            idx     = int'(addr >> 2);
            flt     = (ren || wen) && !is_mmio && !is_ram;
            if (ren) begin
                if (is_mmio) begin
                    if (off == 32'h00)      m_rdata = m_mtime[31:0];
                    else if (off == 32'h04) m_rdata = m_mtime[63:32];
                    else if (off == 32'h08) m_rdata = m_cmp[31:0];
                    else if (off == 32'h0C) m_rdata = m_cmp[63:32];
                    else if (off == 32'h10) m_rdata = {16'h0, m_presc};
                    else                    m_rdata = 32'h0;
                end else if (is_ram) begin
                    m_rdata = m_mem[idx];
                end else begin
                    m_rdata = 32'h0;
                end
            end
            // Timer step: mtime advances once the counter has reached prescale.
            t_n = m_mtime;
            if (m_cnt >= int'(m_presc)) begin
                t_n   = m_mtime + 64'd1;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            c_n = m_cmp;
            p_n = m_presc;
            if (wen && is_ram) m_mem[idx] = merge(m_mem[idx], wdata, be);
            if (wen && is_mmio) begin
                if (off == 32'h00)      t_n[31:0]  = merge(t_n[31:0], wdata, be);
                else if (off == 32'h04) t_n[63:32] = merge(t_n[63:32], wdata, be);
                else if (off == 32'h08) c_n[31:0]  = merge(c_n[31:0], wdata, be);
                else if (off == 32'h0C) c_n[63:32] = merge(c_n[63:32], wdata, be);
                else if (off == 32'h10) p_n        = 16'(merge({16'h0, m_presc}, wdata, be));
            end
            m_mtime = t_n;
            m_cmp   = c_n;
            m_presc = p_n;
            exp_q.push_back({(t_n >= c_n), flt, m_rdata});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] got, e;
        got = {pending, fault, rdata};
        if (rst) begin
            n_cmp++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got pend=%b flt=%b rdata=%h, want all zero", pending, fault, rdata);
            end
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_underflow at %0t: no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL resp at %0t: got pend=%b flt=%b rdata=%h, want pend=%b flt=%b rdata=%h",
                         $time, got[33], got[32], got[31:0], e[33], e[32], e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        #1;
        ren = r; wen = w; addr = a; wdata = d; be = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        cyc(1'b0, 1'b1, a, d, b);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 5) begin
            if ($urandom_range(0, 15) == 0) return 32'h0000_3FFC;
            return 32'($urandom_range(0, 63)) << 2;
        end
        if (k < 8) return MMIO + (32'($urandom_range(0, 7)) << 2);
        case ($urandom_range(0, 3))
            0:       return 32'h0000_4000;
            1:       return 32'h4000_0000;
            2:       return 32'h7FFF_FFFC;
            default: return MMIO + 32'h100;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Prefill every RAM word the random phase may touch.
        for (int i = 0; i < 64; i++) wr(32'(i) << 2, $urandom, 4'hF);
        wr(32'h0000_3FFC, $urandom, 4'hF);

        // RAM write then read
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        // Byte lanes, and the empty mask as a no-op
        wr(32'h10, 32'h0000_00AA, 4'b0001);
        rd(32'h10);
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h10);
        // Read-before-write in the same cycle
        wr(32'h10, 32'h1111_1111, 4'hF);
        cyc(1'b1, 1'b1, 32'h10, 32'h2222_2222, 4'hF);
        rd(32'h10);
        // Unmapped accesses, including the first byte past the RAM
        rd(32'h4000_0000);
        idle(1);
        wr(32'h0000_4000, 32'h5555_5555, 4'hF);
        rd(32'h0000_4000);
        rd(32'h10);
        rd(32'h0000_3FFC);

        // Timer compare
        wr(MMIO + 32'h10, 32'h0, 4'hF);
        wr(MMIO + 32'h0C, 32'h0, 4'hF);
        wr(MMIO + 32'h08, 32'd20, 4'hF);
        wr(MMIO + 32'h04, 32'h0, 4'hF);
        wr(MMIO + 32'h00, 32'h0, 4'hF);
        idle(25);
        wr(MMIO + 32'h08, 32'd1000, 4'hF);
        rd(MMIO + 32'h08);
        rd(MMIO + 32'h00);
        idle(2);

        // Wrap of the 64-bit mtime, then a reset mid-run
        wr(MMIO + 32'h04, 32'hFFFF_FFFF, 4'hF);
        wr(MMIO + 32'h00, 32'hFFFF_FFFE, 4'hF);
        for (int i = 0; i < 3; i++) begin
            rd(MMIO + 32'h00);
            rd(MMIO + 32'h04);
        end
        do_reset(2);
        rd(32'h10);
        rd(MMIO + 32'h00);
        rd(MMIO + 32'h08);

        // Prescaler: with prescale = 3, mtime advances once every 4 cycles
        wr(MMIO + 32'h10, 32'd3, 4'b0011);
        for (int i = 0; i < 10; i++) rd(MMIO + 32'h00);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic r, w;
            logic [31:0] a;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 2) == 0);
            a = rand_addr();
            if (a == MMIO + 32'h10 && w) cyc(r, w, a, 32'($urandom_range(0, 4)), 4'($urandom_range(0, 15)));
            else cyc(r, w, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 400) == 0) do_reset(1);
        end
        idle(3);

        @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
